// File: rtl/mux_scan_seq_if.sv
// Handshake bundle between mux_scan_seq and its mux/word consumer.
// Optional SCAN_PARITY_EN adds word_par alongside word.
interface mux_scan_seq_if #(
    parameter int NUM_SEL_BITS = 2
);
    localparam int N = 2 ** NUM_SEL_BITS;

    logic                    start;
    logic                    q_in;
    logic [NUM_SEL_BITS-1:0] select;
    logic [N-1:0]            word;
    logic                    word_valid;
    logic                    word_ready;
    logic                    busy;
`ifdef SCAN_PARITY_EN
    logic                    word_par;

    modport master (
        input  start, q_in, word_ready,
        output select, word, word_valid, busy, word_par
    );

    modport slave (
        output start, q_in, word_ready,
        input  select, word, word_valid, busy, word_par
    );
`else
    modport master (
        input  start, q_in, word_ready,
        output select, word, word_valid, busy
    );

    modport slave (
        output start, q_in, word_ready,
        input  select, word, word_valid, busy
    );
`endif
endinterface

// File: rtl/mux_scan_seq.sv
// Steps a 4:1-style mux select through every channel, samples q after a settle delay
// and presents the assembled word on valid/ready. Optional macro: SCAN_PARITY_EN (word_par).
module mux_scan_seq #(
    parameter int NUM_SEL_BITS  = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    mux_scan_seq_if.master     bus
);
    localparam int N     = 2 ** NUM_SEL_BITS;
    localparam int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]        SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
    localparam logic [NUM_SEL_BITS-1:0] LAST_SEL   = NUM_SEL_BITS'(N - 1);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [N-1:0]            scratch;
    logic [NUM_SEL_BITS-1:0] select_r;
    logic [N-1:0]            word_r;
    logic                    word_valid_r;
    logic                    busy_r;

    logic [N-1:0]            scratch_nxt;
    logic                    settle_done;
    logic                    last_chan;
    logic                    handshake;

    function automatic logic [N-1:0] insert_bit(
        input logic [N-1:0]            v,
        input logic [NUM_SEL_BITS-1:0] idx,
        input logic                    b
    );
        logic [N-1:0] r;
        r      = v;
        r[idx] = b;
        return r;
    endfunction

    // The final sample is folded in combinationally so word is complete on HOLD entry.
    assign scratch_nxt = insert_bit(scratch, select_r, bus.q_in);
    assign settle_done = (cnt == SETTLE_MAX);
    assign last_chan   = (select_r == LAST_SEL);
    assign handshake   = word_valid_r & bus.word_ready;

`ifdef SCAN_PARITY_EN
    logic word_par_r;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            scratch      <= '0;
            select_r     <= '0;
            word_r       <= '0;
            word_valid_r <= 1'b0;
            busy_r       <= 1'b0;
`ifdef SCAN_PARITY_EN
            word_par_r   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state    <= SCAN;
                        select_r <= '0;
                        cnt      <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                SCAN: begin
                    if (!settle_done) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        scratch <= scratch_nxt;
                        cnt     <= '0;
                        if (!last_chan) begin
                            select_r <= select_r + NUM_SEL_BITS'(1);
                        end else begin
                            word_r       <= scratch_nxt;
                            word_valid_r <= 1'b1;
                            state        <= HOLD;
`ifdef SCAN_PARITY_EN
                            word_par_r   <= ^scratch_nxt;
`endif
                        end
                    end
                end
                HOLD: begin
                    // start is only honoured on the accepting edge; otherwise it is dropped.
                    if (handshake) begin
                        word_valid_r <= 1'b0;
                        select_r     <= '0;
                        cnt          <= '0;
                        if (bus.start) begin
                            state <= SCAN;
                        end else begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.select     = select_r;
    assign bus.word       = word_r;
    assign bus.word_valid = word_valid_r;
    assign bus.busy       = busy_r;
`ifdef SCAN_PARITY_EN
    assign bus.word_par   = word_par_r;
`endif

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq: three instances (settle 1, 0, 2) each read back a modelled
// mux q_in = d[select]; SCAN_PARITY_EN enables the parity scenario.
module tb_mux_scan_seq;
    localparam int SB = 2;
    localparam int N  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_scan_seq_if #(.NUM_SEL_BITS(SB)) b1 ();
    mux_scan_seq_if #(.NUM_SEL_BITS(SB)) b0 ();
    mux_scan_seq_if #(.NUM_SEL_BITS(SB)) b2 ();

    logic [N-1:0] d1, d0, d2;
    assign b1.q_in = d1[b1.select];
    assign b0.q_in = d0[b0.select];
    assign b2.q_in = d2[b2.select];

    mux_scan_seq #(.NUM_SEL_BITS(SB), .SETTLE_CYCLES(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    mux_scan_seq #(.NUM_SEL_BITS(SB), .SETTLE_CYCLES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    mux_scan_seq #(.NUM_SEL_BITS(SB), .SETTLE_CYCLES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    int total = 0;
    int bad   = 0;
    logic [N-1:0] sb1[$];
    logic [N-1:0] sb0[$];
    logic [N-1:0] sb2[$];

    function automatic logic get_valid(input int s);
        case (s)
            0:       return b0.word_valid;
            2:       return b2.word_valid;
            default: return b1.word_valid;
        endcase
    endfunction

    function automatic logic [N-1:0] get_word(input int s);
        case (s)
            0:       return b0.word;
            2:       return b2.word;
            default: return b1.word;
        endcase
    endfunction

    function automatic logic get_busy(input int s);
        case (s)
            0:       return b0.busy;
            2:       return b2.busy;
            default: return b1.busy;
        endcase
    endfunction

    task automatic set_start(input int s, input logic v);
        case (s)
            0:       b0.start = v;
            2:       b2.start = v;
            default: b1.start = v;
        endcase
    endtask

    task automatic pulse_start(input int s);
        set_start(s, 1'b1);
        @(negedge clk);
        set_start(s, 1'b0);
    endtask

    task automatic wait_valid(input int s, input int limit, output int cyc, output bit ok);
        cyc = 0;
        while (!get_valid(s) && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        ok = get_valid(s);
    endtask

    task automatic test_reset;
        int cyc;
        bit ok;
        repeat (2) @(negedge clk);
        total++;
        if (b1.select !== 2'd0 || b1.word !== 4'd0 || b1.word_valid !== 1'b0 || b1.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_init: sel=%0d word=%b vld=%b busy=%b want 0/0000/0/0",
                     b1.select, b1.word, b1.word_valid, b1.busy);
        end
        rst_n = 1'b1;
        d1 = 4'b1010;
        b1.word_ready = 1'b1;
        pulse_start(1);
        wait_valid(1, 30, cyc, ok);
        @(negedge clk);
        total++;
        if (b1.word !== 4'b1010) begin
            bad++;
            $display("FAIL reset_prescan_word: got %b want 1010", b1.word);
        end
        pulse_start(1);
        repeat (2) @(negedge clk);
        total++;
        if (b1.select !== 2'd1 || b1.busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_prescan_sel: sel=%0d busy=%b want 1/1", b1.select, b1.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (b1.select !== 2'd0 || b1.word !== 4'd0 || b1.word_valid !== 1'b0 || b1.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_async: sel=%0d word=%b vld=%b busy=%b want 0/0000/0/0",
                     b1.select, b1.word, b1.word_valid, b1.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [N-1:0] exp;
        d1 = 4'b1010;
        b1.word_ready = 1'b1;
        sb1.push_back(d1);
        pulse_start(1);
        for (int i = 0; i < 8; i++) begin
            total++;
            if (b1.select !== 2'(i / 2) || b1.word_valid !== 1'b0 || b1.busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_seq[%0d]: sel=%0d vld=%b busy=%b want %0d/0/1",
                         i, b1.select, b1.word_valid, b1.busy, i / 2);
            end
            @(negedge clk);
        end
        exp = sb1.pop_front();
        total++;
        if (b1.word_valid !== 1'b1 || b1.word !== exp) begin
            bad++;
            $display("FAIL basic_word: vld=%b word=%b want 1/%b", b1.word_valid, b1.word, exp);
        end
        @(negedge clk);
        total++;
        if (b1.word_valid !== 1'b0 || b1.busy !== 1'b0 || b1.select !== 2'd0 || b1.word !== exp) begin
            bad++;
            $display("FAIL basic_idle: vld=%b busy=%b sel=%0d word=%b want 0/0/0/%b",
                     b1.word_valid, b1.busy, b1.select, b1.word, exp);
        end
    endtask

    task automatic test_sweep;
        logic [N-1:0] exp;
        int cyc;
        bit ok;
        int s;
        int lat;
        b0.word_ready = 1'b1;
        b2.word_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            s   = (k == 0) ? 0 : 2;
            lat = N * (s + 1);
            for (int v = 0; v < 16; v++) begin
                if (s == 0) begin
                    d0 = 4'(v);
                    sb0.push_back(4'(v));
                end else begin
                    d2 = 4'(v);
                    sb2.push_back(4'(v));
                end
                pulse_start(s);
                wait_valid(s, 40, cyc, ok);
                total++;
                if (!ok || cyc != lat) begin
                    bad++;
                    $display("FAIL sweep_latency s=%0d d=%0d: got %0d edges (valid=%b) want %0d",
                             s, v, cyc, ok, lat);
                end
                exp = (s == 0) ? sb0.pop_front() : sb2.pop_front();
                total++;
                if (get_word(s) !== exp) begin
                    bad++;
                    $display("FAIL sweep_word s=%0d: got %b want %b", s, get_word(s), exp);
                end
                @(negedge clk);
                total++;
                if (get_busy(s) !== 1'b0 || get_valid(s) !== 1'b0) begin
                    bad++;
                    $display("FAIL sweep_idle s=%0d: busy=%b vld=%b want 0/0", s, get_busy(s), get_valid(s));
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [N-1:0] exp;
        int cyc;
        bit ok;
        d1 = 4'b0110;
        b1.word_ready = 1'b0;
        sb1.push_back(d1);
        pulse_start(1);
        wait_valid(1, 30, cyc, ok);
        exp = sb1.pop_front();
        for (int i = 0; i < 5; i++) begin
            total++;
            if (b1.word_valid !== 1'b1 || b1.word !== exp || b1.busy !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold[%0d]: vld=%b word=%b busy=%b want 1/%b/1",
                         i, b1.word_valid, b1.word, b1.busy, exp);
            end
            if (i == 0) d1 = 4'b1111;
            @(negedge clk);
        end
        b1.word_ready = 1'b1;
        @(negedge clk);
        total++;
        if (b1.word_valid !== 1'b0 || b1.busy !== 1'b0 || b1.word !== exp) begin
            bad++;
            $display("FAIL bp_release: vld=%b busy=%b word=%b want 0/0/%b",
                     b1.word_valid, b1.busy, b1.word, exp);
        end
    endtask

    task automatic test_start_handling;
        logic [N-1:0] exp;
        int cyc;
        bit ok;
        int extra;
        d1 = 4'b1001;
        b1.word_ready = 1'b1;
        sb1.push_back(d1);
        pulse_start(1);
        repeat (3) @(negedge clk);
        pulse_start(1);
        wait_valid(1, 30, cyc, ok);
        exp = sb1.pop_front();
        total++;
        if (!ok || b1.word !== exp) begin
            bad++;
            $display("FAIL ignore_word: vld=%b word=%b want 1/%b", ok, b1.word, exp);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b1.word_valid === 1'b1) extra++;
        end
        total++;
        if (extra != 0 || b1.busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_extra: extra valid cycles=%0d busy=%b want 0/0", extra, b1.busy);
        end

        d1 = 4'b1100;
        b1.word_ready = 1'b0;
        sb1.push_back(d1);
        pulse_start(1);
        wait_valid(1, 30, cyc, ok);
        exp = sb1.pop_front();
        total++;
        if (!ok || b1.word !== exp) begin
            bad++;
            $display("FAIL b2b_first: vld=%b word=%b want 1/%b", ok, b1.word, exp);
        end
        d1 = 4'b0011;
        sb1.push_back(d1);
        b1.start = 1'b1;
        b1.word_ready = 1'b1;
        @(negedge clk);
        b1.start = 1'b0;
        total++;
        if (b1.word_valid !== 1'b0 || b1.busy !== 1'b1 || b1.select !== 2'd0) begin
            bad++;
            $display("FAIL b2b_restart: vld=%b busy=%b sel=%0d want 0/1/0",
                     b1.word_valid, b1.busy, b1.select);
        end
        wait_valid(1, 30, cyc, ok);
        exp = sb1.pop_front();
        total++;
        if (!ok || cyc != 8 || b1.word !== exp) begin
            bad++;
            $display("FAIL b2b_second: vld=%b edges=%0d word=%b want 1/8/%b", ok, cyc, b1.word, exp);
        end
        @(negedge clk);
    endtask

`ifdef SCAN_PARITY_EN
    task automatic test_parity;
        logic [N-1:0] exp;
        int cyc;
        bit ok;
        d1 = 4'b0111;
        b1.word_ready = 1'b1;
        sb1.push_back(d1);
        pulse_start(1);
        wait_valid(1, 30, cyc, ok);
        exp = sb1.pop_front();
        total++;
        if (!ok || b1.word_par !== ^exp) begin
            bad++;
            $display("FAIL parity_0111: par=%b want %b", b1.word_par, ^exp);
        end
        @(negedge clk);
        d1 = 4'b0101;
        b1.word_ready = 1'b0;
        sb1.push_back(d1);
        pulse_start(1);
        wait_valid(1, 30, cyc, ok);
        exp = sb1.pop_front();
        for (int i = 0; i < 3; i++) begin
            total++;
            if (!ok || b1.word_par !== ^exp || b1.word !== exp) begin
                bad++;
                $display("FAIL parity_hold[%0d]: par=%b word=%b want %b/%b",
                         i, b1.word_par, b1.word, ^exp, exp);
            end
            d1 = 4'b0001;
            @(negedge clk);
        end
        b1.word_ready = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        b1.start = 1'b0;  b0.start = 1'b0;  b2.start = 1'b0;
        b1.word_ready = 1'b0;  b0.word_ready = 1'b0;  b2.word_ready = 1'b0;
        d1 = '0;  d0 = '0;  d2 = '0;
        test_reset();
        test_basic();
        test_sweep();
        test_backpressure();
        test_start_handling();
`ifdef SCAN_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
